uart_tx_serializer: RTL
=======================

// Module: uart_tx_serializer
// PURPOSE
//   Byte-wide UART transmitter on the tester host link; consumes tx_start/tx_data from the
//   serial command parser and returns tx_ready. Serializes each accepted byte as a framed
//   async word (start, LSB-first data, optional parity, stop) on txd_o.
//   Uses a fixed divider off the board clock; no FIFO: one byte in flight.
// PARAMETERS
//   CLK_HZ     50_000_000  input clock frequency, Hz
//   BAUD       115_200     line rate; CLKS_PER_BIT = (CLK_HZ + BAUD/2) / BAUD, must be >= 2
//   DATA_BITS  8           data bits per frame, 5..8; tx_data_i[DATA_BITS-1:0] used
//   PARITY     0           0 none, 1 odd, 2 even
//   STOP_BITS  1           1 or 2
// PORTS
//   clk         in   1  board clock; all logic on its rising edge
//   rstn        in   1  synchronous active-low reset, sampled on rising edge of clk
//   tx_start_i  in   1  request to send tx_data_i; level, sampled only while tx_ready_o=1
//   tx_data_i   in   8  byte to send; captured on the acceptance cycle only
//   tx_ready_o  out  1  1 = idle, can accept; registered
//   txd_o       out  1  serial line, idle high; registered
// BEHAVIOUR
//   Reset (rstn=0 at an edge): state=IDLE, txd_o=1, tx_ready_o=1, bit/baud counters=0,
//     shift reg=0. Applies mid-frame: frame aborted, line high on the next edge, no resume.
//   FSM states: IDLE, START, DATA, PAR, STOP.
//   IDLE: tx_ready_o=1, txd_o=1. Acceptance = tx_ready_o & tx_start_i at an edge: latch
//     tx_data_i, clear counters, go START; tx_ready_o=0 and txd_o=0 from the next cycle.
//   Each bit occupies exactly CLKS_PER_BIT cycles: baud counter 0..CLKS_PER_BIT-1, bit
//     advances when counter = CLKS_PER_BIT-1 (counter width clog2(CLKS_PER_BIT)).
//   START: txd_o=0 -> DATA.  DATA: txd_o=shift[0], shift right per bit, bit counter
//     0..DATA_BITS-1 -> PAR if PARITY!=0 else STOP.
//   PAR: txd_o = ^data (even) or ~^data (odd), computed over the DATA_BITS bits latched.
//   STOP: txd_o=1 for STOP_BITS*CLKS_PER_BIT cycles -> IDLE; tx_ready_o=1 the cycle after
//     the last stop cycle, no extra guard gap.
//   Frame length F = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles;
//     tx_ready_o is low for exactly F cycles per byte.
//   tx_start_i held high across IDLE re-entry: new frame accepted in the first IDLE cycle;
//     tx_ready_o high for exactly 1 cycle between frames (back-to-back streaming).
//   1-cycle tx_start_i pulse while ready is sufficient; pulse while busy is ignored, not queued.
//   tx_data_i / tx_start_i changes during a frame have no effect on txd_o.
//   Invalid params (CLKS_PER_BIT<2, DATA_BITS outside 5..8, PARITY>2, STOP_BITS not 1/2):
//     elaboration-time $error; no runtime fallback.
// TESTING  (CLK_HZ=1_000_000, BAUD=100_000 -> CLKS_PER_BIT=10 unless noted)
//   8N1, pulse start 1 cycle with 0x55 -> txd 0,1,0,1,0,1,0,1,0,1 each 10 cycles; ready low 100.
//   PARITY=2, 0x07 -> parity bit 1; PARITY=1, 0x00 -> parity bit 1; ready low 110 cycles.
//   STOP_BITS=2, 0xA3 -> txd high 20 cycles after data; ready low 110 cycles.
//   start held high, data 0x41 then 0x42 -> two contiguous frames, ready high 1 cycle between.
//   rstn=0 for 1 cycle at cycle 37 of a frame -> next cycle txd=1, ready=1; then 0x0F sends cleanly.
//   parser handshake model (start until ready falls), 20-byte message -> bytes decoded in order,
//     start/data toggling during frames never corrupts txd.

Source files
------------

// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the serial command parser (master) and the UART transmitter (slave).
interface uart_tx_serializer_if;
  logic       tx_start_i;
  logic [7:0] tx_data_i;
  logic       tx_ready_o;

  modport master (output tx_start_i, tx_data_i, input tx_ready_o);
  modport slave  (input tx_start_i, tx_data_i, output tx_ready_o);
endinterface

// File: rtl/uart_tx_serializer.sv
// Single-byte UART transmitter: start, LSB-first data, optional parity, 1-2 stop bits on txd_o.
// One byte in flight; fixed baud divider derived from CLK_HZ/BAUD.
module uart_tx_serializer #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  uart_tx_serializer_if.slave        bus,
  output logic                       txd_o
);

  localparam int unsigned CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [7:0]       DATA_MASK = 8'((9'd1 << DATA_BITS) - 9'd1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_serializer: DATA_BITS must be 5..8");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t           state,    state_nxt;
  logic [CNT_W-1:0] baud_cnt, baud_nxt;
  logic [2:0]       bit_cnt,  bit_nxt;
  logic [7:0]       shift,    shift_nxt;
  logic             par_bit,  par_nxt;
  logic             txd_nxt,  ready_nxt;
  logic             bit_end;
  logic [7:0]       data_masked;

  assign bit_end     = (baud_cnt == CNT_LAST);
  assign data_masked = bus.tx_data_i & DATA_MASK;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    par_nxt   = par_bit;

    if (state != IDLE) begin
      baud_nxt = bit_end ? '0 : baud_cnt + CNT_W'(1);
    end

    unique case (state)
      IDLE: begin
        if (bus.tx_ready_o && bus.tx_start_i) begin
          state_nxt = START;
          baud_nxt  = '0;
          bit_nxt   = '0;
          shift_nxt = data_masked;
          par_nxt   = (PARITY == 2) ? ^data_masked : ~^data_masked;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          bit_nxt   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt = shift >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_nxt   = '0;
            state_nxt = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_nxt = bit_cnt + 3'd1;
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_nxt = STOP;
          bit_nxt   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            state_nxt = IDLE;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_cnt + 3'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered: decode the line level for the state we are about to enter.
    txd_nxt   = 1'b1;
    ready_nxt = (state_nxt == IDLE);
    unique case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shift_nxt[0];
      PAR:     txd_nxt = par_nxt;
      default: txd_nxt = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: the shift register is cleared too so an aborted frame leaves no stale data behind.
      state          <= IDLE;
      baud_cnt       <= '0;
      bit_cnt        <= '0;
      shift          <= '0;
      par_bit        <= 1'b0;
      txd_o          <= 1'b1;
      bus.tx_ready_o <= 1'b1;
    end else begin
      state          <= state_nxt;
      baud_cnt       <= baud_nxt;
      bit_cnt        <= bit_nxt;
      shift          <= shift_nxt;
      par_bit        <= par_nxt;
      txd_o          <= txd_nxt;
      bus.tx_ready_o <= ready_nxt;
    end
  end

endmodule
